// File: rtl/ascon_output_serializer_pkg.sv
// ascon_out_pkg
//   Shared types and constants for the ASCON output serializer.
//   - state_t        : serializer FSM states
//   - BYTES_PER_WORD : bytes in one cipher block (default geometry)
//   - TAG_BYTES      : bytes in the authentication tag (default geometry)
//   - *_CNT_W        : byte-counter widths derived from the constants above
//   - cnt_width()    : counter width for an n-entry sequence (at least 1 bit)
package ascon_out_pkg;

   localparam int unsigned DEF_WORD_W = 64;
   localparam int unsigned DEF_TAG_W  = 128;

   localparam int unsigned BYTES_PER_WORD = DEF_WORD_W / 8;
   localparam int unsigned TAG_BYTES      = DEF_TAG_W / 8;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned WORD_CNT_W = cnt_width(BYTES_PER_WORD);
   localparam int unsigned TAG_CNT_W  = cnt_width(TAG_BYTES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CIPHER = 2'd1,
      TAG    = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/ascon_output_serializer_fifo.sv
// fifo_sync_word
//   Single-clock word FIFO with synchronous active-low reset and a
//   synchronous clear. A push while full is accepted only when a pop
//   happens in the same cycle; a pop while empty is ignored.
//   Ports:
//     clk        : clock, rising edge
//     resetb     : synchronous active-low reset
//     clear      : synchronous flush (same effect as reset)
//     push       : write push_data at the tail
//     push_data  : word to write
//     pop        : drop the head word
//     full/empty : occupancy flags
//     head_data  : word at the head
//     head_next  : word behind the head (valid when count >= 2)
//     count      : number of stored words, equals DEPTH when full
module fifo_sync_word #(
   parameter  int unsigned WIDTH = 64,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data,
   output logic [WIDTH-1:0] head_next,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full      = (count == CNT_W'(DEPTH));
      empty     = (count == '0);
      do_pop    = pop & ~empty;
      do_push   = push & (~full | do_pop);
      head_data = mem[rd_ptr];
      head_next = mem[rd_ptr + PTR_W'(1)];
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetb || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ascon_output_serializer.sv
// ascon_output_serializer
//   Captures cipher blocks and the final tag from the ASCON control FSM and
//   streams them MSB-first, one byte per transfer, on a valid/ready port.
//   Cipher bytes go out first, tag bytes last.
//   Ports:
//     clock_i        : clock, rising edge
//     resetb_i       : synchronous active-low reset
//     start_i        : new message, flushes all buffered content
//     cipher_valid_i : strobe, cipher_i holds a block
//     cipher_i       : cipher block
//     end_i          : strobe, tag_i holds the tag, message finished
//     tag_i          : authentication tag
//     byte_o         : output byte
//     byte_valid_o   : byte_o valid
//     byte_ready_i   : consumer accepts byte_o
//     byte_last_o    : final tag byte
//     is_tag_o       : current byte belongs to the tag
//     overflow_o     : sticky, a cipher block was dropped
//     busy_o         : data buffered or in flight
//     done_o         : one-cycle pulse after the last tag byte transfers
module ascon_output_serializer
   import ascon_out_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WORD_W     = DEF_WORD_W,
   parameter int unsigned TAG_W      = DEF_TAG_W
) (
   input  logic              clock_i,
   input  logic              resetb_i,
   input  logic              start_i,
   input  logic              cipher_valid_i,
   input  logic [WORD_W-1:0] cipher_i,
   input  logic              end_i,
   input  logic [TAG_W-1:0]  tag_i,
   output logic [7:0]        byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   output logic              byte_last_o,
   output logic              is_tag_o,
   output logic              overflow_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned WBYTES = WORD_W / 8;
   localparam int unsigned TBYTES = TAG_W / 8;
   localparam int unsigned WCNT_W = cnt_width(WBYTES);
   localparam int unsigned TCNT_W = cnt_width(TBYTES);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

   state_t              state;
   logic [WCNT_W-1:0]   wcnt;
   logic [TCNT_W-1:0]   tcnt;
   logic [TAG_W-1:0]    tag_q;
   logic                tag_pending;

   logic                fifo_full;
   logic                fifo_empty;
   logic [WORD_W-1:0]   head_word;
   logic [WORD_W-1:0]   head_next;
   logic [CNT_W-1:0]    fifo_count;

   logic                xfer;
   logic                last_wbyte;
   logic                last_tbyte;
   logic                pop;
   logic                push;
   logic                refill;
   logic [WORD_W-1:0]   next_word;
   logic                tag_accept;

   function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input int k);
      logic [WORD_W-1:0] s;
      s = w << (8 * k);
      return s[WORD_W-1 -: 8];
   endfunction

   function automatic logic [7:0] tag_byte(input logic [TAG_W-1:0] t, input int k);
      logic [TAG_W-1:0] s;
      s = t << (8 * k);
      return s[TAG_W-1 -: 8];
   endfunction

   always_comb begin
      xfer       = byte_valid_o & byte_ready_i;
      last_wbyte = (wcnt == WCNT_W'(WBYTES - 1));
      last_tbyte = (tcnt == TCNT_W'(TBYTES - 1));
      pop        = (state == CIPHER) & xfer & last_wbyte;
      push       = cipher_valid_i & ~start_i & (~fifo_full | pop);
      // After a pop the FIFO still holds a word if two were stored, or if
      // a block arrives in the same cycle; that word becomes the new head
      // and must be loaded now so the stream has no bubble.
      refill     = (fifo_count >= CNT_W'(2)) | push;
      next_word  = (fifo_count >= CNT_W'(2)) ? head_next : cipher_i;
      tag_accept = end_i & ~start_i & ~tag_pending & (state != TAG);
      busy_o     = ~fifo_empty | tag_pending | (state != IDLE);
   end

   fifo_sync_word #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_i),
      .resetb    (resetb_i),
      .clear     (start_i),
      .push      (push),
      .push_data (cipher_i),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_data (head_word),
      .head_next (head_next),
      .count     (fifo_count)
   );

   always_ff @(posedge clock_i) begin
      if (!resetb_i || start_i) begin
         state        <= IDLE;
         wcnt         <= '0;
         tcnt         <= '0;
         tag_q        <= '0;
         tag_pending  <= 1'b0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         byte_last_o  <= 1'b0;
         is_tag_o     <= 1'b0;
         overflow_o   <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;

         if (cipher_valid_i && !push) begin
            overflow_o <= 1'b1;
         end

         if (tag_accept) begin
            tag_q       <= tag_i;
            tag_pending <= 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  state        <= CIPHER;
                  wcnt         <= '0;
                  byte_o       <= word_byte(head_word, 0);
                  byte_valid_o <= 1'b1;
                  is_tag_o     <= 1'b0;
                  byte_last_o  <= 1'b0;
               end else if (tag_pending) begin
                  state        <= TAG;
                  tcnt         <= '0;
                  byte_o       <= tag_byte(tag_q, 0);
                  byte_valid_o <= 1'b1;
                  is_tag_o     <= 1'b1;
                  byte_last_o  <= (TBYTES == 1);
               end
            end

            CIPHER: begin
               if (xfer) begin
                  if (last_wbyte) begin
                     wcnt <= '0;
                     if (refill) begin
                        byte_o <= word_byte(next_word, 0);
                     end else if (tag_pending) begin
                        state       <= TAG;
                        tcnt        <= '0;
                        byte_o      <= tag_byte(tag_q, 0);
                        is_tag_o    <= 1'b1;
                        byte_last_o <= (TBYTES == 1);
                     end else begin
                        state        <= IDLE;
                        byte_o       <= '0;
                        byte_valid_o <= 1'b0;
                     end
                  end else begin
                     wcnt   <= wcnt + WCNT_W'(1);
                     byte_o <= word_byte(head_word, int'(wcnt) + 1);
                  end
               end
            end

            TAG: begin
               if (xfer) begin
                  if (last_tbyte) begin
                     state        <= DONE;
                     tcnt         <= '0;
                     tag_pending  <= 1'b0;
                     byte_o       <= '0;
                     byte_valid_o <= 1'b0;
                     byte_last_o  <= 1'b0;
                     is_tag_o     <= 1'b0;
                     done_o       <= 1'b1;
                  end else begin
                     tcnt        <= tcnt + TCNT_W'(1);
                     byte_o      <= tag_byte(tag_q, int'(tcnt) + 1);
                     byte_last_o <= (tcnt == TCNT_W'(TBYTES - 2));
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_output_serializer.sv
// tb_ascon_output_serializer
//   Directed stimulus for ascon_output_serializer with a byte-stream
//   reference model: accepted blocks are queued as whole words, the tag is
//   held as a value, and every transfer is checked against the next byte the
//   queue/tag must yield (MSB first, cipher before tag).
module tb_ascon_output_serializer;
   import ascon_out_pkg::*;

   localparam int DEPTH = 4;

   logic         clk;
   logic         resetb;
   logic         start;
   logic         cv;
   logic [63:0]  cipher;
   logic         end_strobe;
   logic [127:0] tag;
   logic [7:0]   byte_o;
   logic         byte_valid_o;
   logic         ready;
   logic         byte_last_o;
   logic         is_tag_o;
   logic         overflow_o;
   logic         busy_o;
   logic         done_o;

   ascon_output_serializer #(
      .FIFO_DEPTH (DEPTH),
      .WORD_W     (64),
      .TAG_W      (128)
   ) dut (
      .clock_i        (clk),
      .resetb_i       (resetb),
      .start_i        (start),
      .cipher_valid_i (cv),
      .cipher_i       (cipher),
      .end_i          (end_strobe),
      .tag_i          (tag),
      .byte_o         (byte_o),
      .byte_valid_o   (byte_valid_o),
      .byte_ready_i   (ready),
      .byte_last_o    (byte_last_o),
      .is_tag_o       (is_tag_o),
      .overflow_o     (overflow_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_b(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0]  m_words[$];
   int           m_sent;
   int           m_tag_sent;
   logic         m_tag_pend;
   logic [127:0] m_tag;
   logic         m_ovf;
   logic         m_done;
   logic         m_init = 1'b0;
   logic         m_accept;
   logic         m_is_word;
   logic         mx;
   logic [7:0]   eb;
   logic         et;
   logic         el;
   logic         p_stall = 1'b0;
   logic [7:0]   p_byte;
   logic         p_tag;
   logic         p_last;
   logic [9:0]   obs_q[$];

   function automatic logic [7:0] byte_of_word(input logic [63:0] w, input int k);
      return w[63 - 8*k -: 8];
   endfunction

   function automatic logic [7:0] byte_of_tag(input logic [127:0] t, input int k);
      return t[127 - 8*k -: 8];
   endfunction

   function automatic logic m_has();
      return (m_words.size() > 0) || m_tag_pend;
   endfunction

   // Inputs change 2 time units after posedge, so at negedge both the DUT
   // outputs and the inputs for the coming edge are stable.
   always @(negedge clk) begin
      if (m_init) begin
         if (p_stall) begin
            chk_b("hold_valid", byte_valid_o, 1'b1);
            chk_8("hold_byte", byte_o, p_byte);
            chk_b("hold_is_tag", is_tag_o, p_tag);
            chk_b("hold_last", byte_last_o, p_last);
         end
         if (!m_has()) chk_b("idle_valid", byte_valid_o, 1'b0);
         chk_b("done", done_o, m_done);
         chk_b("overflow", overflow_o, m_ovf);
         chk_b("busy", busy_o, m_has() | m_done);
      end

      mx = m_init && resetb && !start && byte_valid_o && ready;
      m_is_word = (m_words.size() > 0) && (m_tag_sent == 0);
      if (mx) begin
         chk_b("xfer_expected", m_has(), 1'b1);
         if (m_is_word) begin
            eb = byte_of_word(m_words[0], m_sent);
            et = 1'b0;
            el = 1'b0;
         end else begin
            eb = byte_of_tag(m_tag, m_tag_sent);
            et = 1'b1;
            el = (m_tag_sent == int'(TAG_BYTES) - 1);
         end
         chk_8("stream_byte", byte_o, eb);
         chk_b("stream_is_tag", is_tag_o, et);
         chk_b("stream_last", byte_last_o, el);
         obs_q.push_back({is_tag_o, byte_last_o, byte_o});
      end

      p_stall = m_init && resetb && !start && byte_valid_o && !ready;
      p_byte  = byte_o;
      p_tag   = is_tag_o;
      p_last  = byte_last_o;

      if (!resetb || start) begin
         m_words.delete();
         m_sent     = 0;
         m_tag_sent = 0;
         m_tag_pend = 1'b0;
         m_tag      = '0;
         m_ovf      = 1'b0;
         m_done     = 1'b0;
         m_init     = 1'b1;
         p_stall    = 1'b0;
      end else if (m_init) begin
         m_done   = 1'b0;
         m_accept = 1'b0;
         if (cv) begin
            if (m_words.size() < DEPTH ||
                (mx && m_is_word && m_sent == int'(BYTES_PER_WORD) - 1))
               m_accept = 1'b1;
            else
               m_ovf = 1'b1;
         end
         if (end_strobe && !m_tag_pend) begin
            m_tag      = tag;
            m_tag_pend = 1'b1;
         end
         if (mx) begin
            if (m_is_word) begin
               m_sent++;
               if (m_sent == int'(BYTES_PER_WORD)) begin
                  m_sent = 0;
                  void'(m_words.pop_front());
               end
            end else if (m_tag_pend) begin
               m_tag_sent++;
               if (m_tag_sent == int'(TAG_BYTES)) begin
                  m_tag_sent = 0;
                  m_tag_pend = 1'b0;
                  m_done     = 1'b1;
               end
            end
         end
         if (m_accept) m_words.push_back(cipher);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic run_until_done(input string name, input int limit);
      int i;
      i = 0;
      while (done_o !== 1'b1 && i < limit) begin
         cyc();
         i++;
      end
      chk_b({name, "_done_seen"}, done_o, 1'b1);
   endtask

   function automatic logic [63:0] t4_word(input int k);
      return 64'h0001020304050607 + 64'(k) * 64'h1010101010101010;
   endfunction

   logic [7:0] t2_exp [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
   logic [7:0] t5_exp [8] = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
   int vcount;
   int ntag;

   initial begin
      resetb = 1'b0; start = 1'b0; cv = 1'b0; cipher = '0;
      end_strobe = 1'b0; tag = '0; ready = 1'b0;
      cyc(); cyc();
      chk_b("rst_valid", byte_valid_o, 1'b0);
      chk_8("rst_byte", byte_o, 8'h00);
      chk_b("rst_last", byte_last_o, 1'b0);
      chk_b("rst_is_tag", is_tag_o, 1'b0);
      chk_b("rst_overflow", overflow_o, 1'b0);
      chk_b("rst_busy", busy_o, 1'b0);
      chk_b("rst_done", done_o, 1'b0);
      resetb = 1'b1;
      cyc();

      // 1: reset after three bytes of a word
      obs_q.delete();
      ready = 1'b1;
      cipher = 64'h0011223344556677; cv = 1'b1; cyc(); cv = 1'b0;
      repeat (4) cyc();
      resetb = 1'b0; cyc();
      chk_b("t1_valid", byte_valid_o, 1'b0);
      chk_8("t1_byte", byte_o, 8'h00);
      chk_b("t1_is_tag", is_tag_o, 1'b0);
      chk_b("t1_last", byte_last_o, 1'b0);
      chk_b("t1_busy", busy_o, 1'b0);
      resetb = 1'b1;
      repeat (10) cyc();
      chk_i("t1_count", obs_q.size(), 3);
      chk_8("t1_b0", obs_q[0][7:0], 8'h00);
      chk_8("t1_b1", obs_q[1][7:0], 8'h11);
      chk_8("t1_b2", obs_q[2][7:0], 8'h22);

      // 2: one word then tag, full-rate stream
      obs_q.delete();
      cipher = 64'h0123456789ABCDEF; cv = 1'b1; cyc(); cv = 1'b0;
      chk_b("t2_lat_valid0", byte_valid_o, 1'b0);
      tag = 128'h000102030405060708090A0B0C0D0E0F; end_strobe = 1'b1; cyc(); end_strobe = 1'b0;
      chk_b("t2_lat_valid1", byte_valid_o, 1'b1);
      chk_8("t2_first_byte", byte_o, 8'h01);
      vcount = 1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (byte_valid_o !== 1'b1) break;
         vcount++;
      end
      chk_i("t2_valid_run", vcount, 24);
      chk_b("t2_done_pulse", done_o, 1'b1);
      cyc();
      chk_b("t2_done_low", done_o, 1'b0);
      chk_i("t2_count", obs_q.size(), 24);
      for (int i = 0; i < 8; i++) chk_8("t2_cipher", obs_q[i][7:0], t2_exp[i]);
      for (int i = 0; i < 16; i++) chk_8("t2_tag", obs_q[8+i][7:0], 8'(i));
      chk_b("t2_tag_flag7", obs_q[7][9], 1'b0);
      chk_b("t2_tag_flag8", obs_q[8][9], 1'b1);
      chk_b("t2_last22", obs_q[22][8], 1'b0);
      chk_b("t2_last23", obs_q[23][8], 1'b1);

      // 3: backpressure, ready toggling each cycle
      obs_q.delete();
      cipher = {8{8'hA5}}; cv = 1'b1; cyc(); cv = 1'b0;
      for (int i = 0; i < 30; i++) begin
         ready = (i % 2 == 0);
         cyc();
      end
      ready = 1'b1;
      chk_i("t3_count", obs_q.size(), 8);
      for (int i = 0; i < 8; i++) chk_8("t3_byte", obs_q[i][7:0], 8'hA5);
      chk_b("t3_busy", busy_o, 1'b0);

      // 4: overflow with consumer stalled
      obs_q.delete();
      ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cipher = t4_word(k); cv = 1'b1; cyc();
      end
      cv = 1'b0;
      cyc();
      chk_b("t4_overflow", overflow_o, 1'b1);
      ready = 1'b1;
      repeat (40) cyc();
      chk_i("t4_count", obs_q.size(), 32);
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 8; j++)
            chk_8("t4_byte", obs_q[8*k+j][7:0], 8'(j + 16*k));
      chk_b("t4_overflow_sticky", overflow_o, 1'b1);

      // 6: start with two words buffered, then tag-only message
      ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cipher = t4_word(k); cv = 1'b1; cyc();
      end
      cv = 1'b0;
      cyc(); cyc();
      cipher = t4_word(2); cv = 1'b1; start = 1'b1; cyc();
      cv = 1'b0; start = 1'b0;
      chk_b("t6_valid", byte_valid_o, 1'b0);
      chk_b("t6_overflow", overflow_o, 1'b0);
      chk_b("t6_busy", busy_o, 1'b0);
      repeat (3) cyc();
      obs_q.delete();
      ready = 1'b1;
      tag = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF; end_strobe = 1'b1; cyc(); end_strobe = 1'b0;
      run_until_done("t6", 40);
      chk_i("t6_count", obs_q.size(), 16);
      for (int i = 0; i < 16; i++) chk_8("t6_tag", obs_q[i][7:0], 8'hF0 + 8'(i));
      chk_b("t6_first_is_tag", obs_q[0][9], 1'b1);
      chk_b("t6_last", obs_q[15][8], 1'b1);
      repeat (3) cyc();

      // 5: same-cycle word and tag, second end_i during tag ignored
      obs_q.delete();
      cipher = 64'hFEDCBA9876543210; tag = 128'h8899AABBCCDDEEFF0011223344556677;
      cv = 1'b1; end_strobe = 1'b1; cyc(); cv = 1'b0; end_strobe = 1'b0;
      repeat (11) cyc();
      chk_b("t5_in_tag", is_tag_o, 1'b1);
      tag = '1; end_strobe = 1'b1; cyc(); end_strobe = 1'b0;
      run_until_done("t5", 40);
      repeat (20) cyc();
      chk_i("t5_count", obs_q.size(), 24);
      for (int i = 0; i < 8; i++) chk_8("t5_cipher", obs_q[i][7:0], t5_exp[i]);
      ntag = 0;
      for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][9]) ntag++;
      chk_i("t5_tag_bytes", ntag, 16);
      chk_8("t5_tag_first", obs_q[8][7:0], 8'h88);
      chk_8("t5_tag_last", obs_q[23][7:0], 8'h77);
      chk_b("t5_busy", busy_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ascon_output_serializer.md
Name: ascon_output_serializer

Overview:
Downstream stage of the ASCON-128 control FSM. It captures each 64-bit cipher block strobed by cipher_valid, and the 128-bit tag strobed by end. It buffers them and streams them out one byte at a time on a valid/ready byte interface, cipher bytes first and tag bytes last. It decouples the fixed-timing permutation core from a slower consumer such as a UART or bus bridge.

Parameters:
FIFO_DEPTH, 4, number of 64-bit cipher words buffered (power of two, >=2)
WORD_W, 64, cipher block width in bits (multiple of 8)
TAG_W, 128, tag width in bits (multiple of 8)

Ports:
clock_i  input  1  single clock, rising edge
resetb_i  input  1  synchronous active-low reset
start_i  input  1  new-message pulse; synchronous clear of all buffered content
cipher_valid_i  input  1  one-cycle strobe: cipher_i holds a valid block
cipher_i  input  WORD_W  cipher block
end_i  input  1  one-cycle strobe: tag_i valid, message finished
tag_i  input  TAG_W  authentication tag
byte_o  output  8  output byte
byte_valid_o  output  1  byte_o valid
byte_ready_i  input  1  consumer accepts byte
byte_last_o  output  1  marks the final tag byte
is_tag_o  output  1  current byte belongs to the tag
overflow_o  output  1  sticky: a cipher word was dropped
busy_o  output  1  data buffered or in flight
done_o  output  1  one-cycle pulse after the last tag byte transfers

Behaviour:
- Reset (resetb_i=0 at a clock edge) has priority over everything. Every output goes to 0 and the FIFO empties. The tag register and the tag_pending flag clear, and the FSM returns to IDLE.
- start_i=1, when not in reset, has the same clearing effect as reset. It wins over cipher_valid_i and end_i in the same cycle; both are ignored.
- Transfer: a byte moves when byte_valid_o && byte_ready_i. While byte_valid_o=1 and byte_ready_i=0, byte_o, byte_last_o and is_tag_o hold stable.
- Byte order: MSB first. Cipher byte k is cipher_i[WORD_W-1-8k -: 8]. Tag bytes follow the same rule on tag_i.
- Push:
  - cipher_valid_i writes cipher_i into the FIFO when count<FIFO_DEPTH.
  - The write is also accepted when the FIFO is full and the head word's final byte transfers in the same cycle.
  - Otherwise the word is dropped and overflow_o is set. It stays set until reset or start_i.
- Tag capture: end_i latches tag_i and sets tag_pending. end_i while tag_pending=1 or in TAG state is ignored.
- Simultaneous cipher_valid_i and end_i are both captured. That word is emitted before the tag.
- FSM:
  - IDLE: byte_valid_o=0. Go to CIPHER if the FIFO is non-empty, else to TAG if tag_pending.
  - CIPHER: presents head-word bytes 0..7 (3-bit counter). After byte 7 transfers, pop the word. Stay in CIPHER if the FIFO is still non-empty, else go to TAG if tag_pending, else go to IDLE.
  - TAG: is_tag_o=1; presents bytes 0..15 (4-bit counter). byte_last_o=1 only on byte 15. After byte 15 transfers, clear tag_pending and go to DONE.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency:
  - A word pushed at edge N with the serializer idle gives byte_valid_o=1 with byte 0 after edge N+1.
  - Back-to-back bytes stream at one per cycle while ready=1.
  - There are no bubbles between consecutive words, or between the last cipher byte and the first tag byte.
- busy_o = (FIFO non-empty) | tag_pending | (state != IDLE).
- Tag-only message (end_i with no cipher words) is legal and emits 16 tag bytes.
- The FIFO count is exactly FIFO_DEPTH when full. Read and write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package ascon_out_pkg holds:
  - state enum {IDLE, CIPHER, TAG, DONE};
  - BYTES_PER_WORD = WORD_W/8 and TAG_BYTES = TAG_W/8;
  - the counter widths derived from those constants.
- One sub-module, fifo_sync_word:
  - parameterised width/depth synchronous FIFO, with active-low synchronous reset and a clear input;
  - exposes push, pop, full, empty, head data and count.
- The serializer FSM and byte mux live in the top module.

Test Plan:
1. Reset mid-stream (after 3 of 8 bytes of word 0x0011223344556677) -> all outputs 0 next cycle, busy_o=0, no further bytes.
2. One cipher word 0x0123456789ABCDEF then end_i with tag 0x00..0F (bytes 00..0F), byte_ready_i=1 -> bytes 01,23,45,67,89,AB,CD,EF then 00..0F with is_tag_o=1 on the tag bytes. byte_last_o on 0F only, done_o pulse the next cycle; 24 consecutive valid cycles.
3. Backpressure: byte_ready_i toggling 1/0 each cycle on word 0xA5A5...A5 -> byte_o stable while ready=0, exactly 8 transfers, all A5.
4. Overflow: byte_ready_i=0, push 5 words -> words 1-4 retained, 5th dropped, overflow_o=1. Releasing ready emits exactly 32 cipher bytes.
5. Same-cycle cipher_valid_i and end_i -> the word's 8 bytes precede the 16 tag bytes. A second end_i during TAG is ignored (exactly 16 tag bytes).
6. start_i asserted with 2 words buffered -> FIFO empty, overflow_o cleared, byte_valid_o=0 next cycle. A following tag-only end_i emits 16 bytes then done_o.
